// File: rtl/tmr_mem_scrubber.sv
// Bank-side scrubber for a triplicated memory: passes voted accesses through to all banks and,
// in idle gaps, reads each word from the three banks and rewrites only the banks that disagree.
module tmr_mem_scrubber #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH_LOG2     = 10,
  parameter int unsigned SCRUB_INTERVAL = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en,
  input  logic [ADDR_WIDTH-1:0] voted_addr,
  input  logic [DATA_WIDTH-1:0] voted_wdata,
  input  logic                  voted_wen,
  input  logic                  voted_ren,
  input  logic [DATA_WIDTH-1:0] rdata_bank_a,
  input  logic [DATA_WIDTH-1:0] rdata_bank_b,
  input  logic [DATA_WIDTH-1:0] rdata_bank_c,
  output logic [ADDR_WIDTH-1:0] bank_addr,
  output logic [DATA_WIDTH-1:0] bank_wdata,
  output logic [2:0]            bank_wen,
  output logic                  bank_ren,
  output logic                  scrub_busy,
  output logic [15:0]           corrections,
  output logic                  triple_fault,
  output logic                  pass_done,
  output logic [DEPTH_LOG2-1:0] last_fault_addr
);

  typedef enum logic [1:0] {StIdle, StRead, StCheck, StWrite} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   maj_q, maj_d, maj_c;
  logic [2:0]              mask_q, mask_d, mask_c;
  logic [15:0]             corr_q, corr_d;
  logic                    triple_q, triple_d;
  logic                    pass_q, pass_d;
  logic [DEPTH_LOG2-1:0]   lfa_q, lfa_d;
  logic                    freq, hazard, all_differ;
  logic                    scrub_rd, scrub_wr, advance;
  logic [ADDR_WIDTH-1:0]   ptr_ext;

  assign ptr_ext    = ADDR_WIDTH'(ptr_q);
  assign freq       = voted_wen | voted_ren;
  assign hazard     = voted_wen && (voted_addr == ptr_ext);
  assign maj_c      = (rdata_bank_a & rdata_bank_b) | (rdata_bank_b & rdata_bank_c) |
                      (rdata_bank_a & rdata_bank_c);
  assign mask_c     = {rdata_bank_c != maj_c, rdata_bank_b != maj_c, rdata_bank_a != maj_c};
  assign all_differ = (rdata_bank_a != rdata_bank_b) && (rdata_bank_b != rdata_bank_c) &&
                      (rdata_bank_a != rdata_bank_c);

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    ptr_d    = ptr_q;
    maj_d    = maj_q;
    mask_d   = mask_q;
    corr_d   = corr_q;
    triple_d = 1'b0;
    pass_d   = 1'b0;
    lfa_d    = lfa_q;
    advance  = 1'b0;
    scrub_rd = 1'b0;
    scrub_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (scrub_en) begin
          if (cnt_q == SCRUB_INTERVAL - 1) state_d = StRead;
          else                             cnt_d   = cnt_q + 32'd1;
        end
      end
      StRead: begin
        if (!scrub_en) begin
          state_d = StIdle;
        end else if (!freq) begin
          scrub_rd = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        // A functional write to the word under test makes the sample stale.
        if (hazard) begin
          state_d = StIdle;
        end else begin
          maj_d  = maj_c;
          mask_d = mask_c;
          if (all_differ) begin
            triple_d = 1'b1;
            lfa_d    = ptr_q;
          end
          if (mask_c == 3'b000) begin
            advance = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (hazard) begin
          state_d = StIdle;
        end else if (!freq) begin
          scrub_wr = 1'b1;
          if (corr_q != 16'hFFFF) corr_d = corr_q + 16'd1;
          lfa_d   = ptr_q;
          advance = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (advance) begin
      ptr_d  = ptr_q + DEPTH_LOG2'(1);
      pass_d = (ptr_q == '1);
    end
  end

  always_comb begin
    bank_addr  = voted_addr;
    bank_wdata = voted_wdata;
    bank_wen   = {3{voted_wen}};
    bank_ren   = voted_ren;
    if (scrub_rd) begin
      bank_addr = ptr_ext;
      bank_ren  = 1'b1;
      bank_wen  = 3'b000;
    end
    if (scrub_wr) begin
      bank_addr  = ptr_ext;
      bank_wdata = maj_q;
      bank_wen   = mask_q;
      bank_ren   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cnt_q    <= '0;
      maj_q    <= '0;
      mask_q   <= '0;
      corr_q   <= '0;
      triple_q <= 1'b0;
      pass_q   <= 1'b0;
      lfa_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      maj_q    <= maj_d;
      mask_q   <= mask_d;
      corr_q   <= corr_d;
      triple_q <= triple_d;
      pass_q   <= pass_d;
      lfa_q    <= lfa_d;
    end
  end

  assign scrub_busy      = (state_q != StIdle);
  assign corrections     = corr_q;
  assign triple_fault    = triple_q;
  assign pass_done       = pass_q;
  assign last_fault_addr = lfa_q;

endmodule

// File: tb/tb_tmr_mem_scrubber.sv
// Directed bench for tmr_mem_scrubber with a 4-word, three-bank memory model behind it.
module tb_tmr_mem_scrubber;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DL = 2;
  localparam int unsigned SI = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scrub_en = 1'b0;
  logic [AW-1:0] voted_addr = '0;
  logic [DW-1:0] voted_wdata = '0;
  logic          voted_wen = 1'b0;
  logic          voted_ren = 1'b0;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [2:0]    bank_wen;
  logic          bank_ren;
  logic          scrub_busy;
  logic [15:0]   corrections;
  logic          triple_fault;
  logic          pass_done;
  logic [DL-1:0] last_fault_addr;

  logic [DW-1:0] mem [3][4] = '{default: '0};
  logic [DW-1:0] rd [3] = '{default: '0};
  logic          ld_we = 1'b0;
  int            ld_bank = 0;
  int            ld_addr = 0;
  logic [DW-1:0] ld_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmr_mem_scrubber #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .DEPTH_LOG2    (DL),
    .SCRUB_INTERVAL(SI)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scrub_en       (scrub_en),
    .voted_addr     (voted_addr),
    .voted_wdata    (voted_wdata),
    .voted_wen      (voted_wen),
    .voted_ren      (voted_ren),
    .rdata_bank_a   (rd[0]),
    .rdata_bank_b   (rd[1]),
    .rdata_bank_c   (rd[2]),
    .bank_addr      (bank_addr),
    .bank_wdata     (bank_wdata),
    .bank_wen       (bank_wen),
    .bank_ren       (bank_ren),
    .scrub_busy     (scrub_busy),
    .corrections    (corrections),
    .triple_fault   (triple_fault),
    .pass_done      (pass_done),
    .last_fault_addr(last_fault_addr)
  );

  // Bank model: synchronous write per bank, read data one cycle after bank_ren.
  always @(posedge clk) begin
    if (ld_we) mem[ld_bank][ld_addr] <= ld_data;
    for (int i = 0; i < 3; i++) begin
      if (bank_wen[i]) mem[i][bank_addr[1:0]] <= bank_wdata;
      if (bank_ren) rd[i] <= mem[i][bank_addr[1:0]];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic load(input int bank, input int addr, input logic [DW-1:0] data);
    tick(1);
    ld_we = 1'b1; ld_bank = bank; ld_addr = addr; ld_data = data;
    tick(1);
    ld_we = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (scrub_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", scrub_busy); end
    checks++; if (corrections !== 16'h0) begin failures++; $display("FAIL reset_corr got=%h exp=0", corrections); end
    checks++; if (last_fault_addr !== 2'd0) begin failures++; $display("FAIL reset_lfa got=%0d exp=0", last_fault_addr); end
    checks++; if ({triple_fault, pass_done} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {triple_fault, pass_done}); end
    checks++; if ({bank_wen, bank_ren} !== 4'b0000) begin failures++; $display("FAIL reset_en got=%b exp=0000", {bank_wen, bank_ren}); end
    voted_ren = 1'b1; voted_addr = 32'h3A; #1;
    checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'h3A) begin failures++; $display("FAIL reset_passthru got=%b/%h exp=1/3a", bank_ren, bank_addr); end
    voted_ren = 1'b0; voted_addr = '0;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_clean_pass;
    scrub_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick(1);
        checks++; if ({bank_wen, bank_ren} !== 4'b0000) begin failures++; $display("FAIL clean_idle_en k=%0d got=%b exp=0000", k, {bank_wen, bank_ren}); end
      end
      tick(1);
      checks++; if (bank_ren !== 1'b1 || bank_addr !== AW'(k) || bank_wen !== 3'b000) begin
        failures++; $display("FAIL clean_read k=%0d got ren=%b addr=%h wen=%b exp ren=1 addr=%0d wen=000", k, bank_ren, bank_addr, bank_wen, k); end
      checks++; if (scrub_busy !== 1'b1) begin failures++; $display("FAIL clean_busy k=%0d got=%b exp=1", k, scrub_busy); end
      tick(1);
      checks++; if ({bank_wen, bank_ren} !== 4'b0000) begin failures++; $display("FAIL clean_check_en k=%0d got=%b exp=0000", k, {bank_wen, bank_ren}); end
      tick(1);
      checks++; if (pass_done !== (k == 3)) begin failures++; $display("FAIL clean_pass_done k=%0d got=%b exp=%b", k, pass_done, k == 3); end
      checks++; if (scrub_busy !== 1'b0 || corrections !== 16'h0) begin failures++; $display("FAIL clean_after k=%0d got busy=%b corr=%h exp 0/0", k, scrub_busy, corrections); end
    end
    scrub_en = 1'b0;
  endtask

  task automatic test_single_correction;
    load(1, 1, 32'h0000_0010);
    scrub_en = 1'b1;
    tick(4);
    checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'd0) begin failures++; $display("FAIL single_read0 got=%b/%h exp=1/0", bank_ren, bank_addr); end
    tick(6);
    checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'd1) begin failures++; $display("FAIL single_read1 got=%b/%h exp=1/1", bank_ren, bank_addr); end
    tick(1);
    checks++; if (bank_wen !== 3'b000) begin failures++; $display("FAIL single_check_wen got=%b exp=000", bank_wen); end
    tick(1);
    checks++; if (bank_wen !== 3'b010 || bank_wdata !== 32'h0 || bank_addr !== 32'd1) begin
      failures++; $display("FAIL single_write got wen=%b wdata=%h addr=%h exp 010/0/1", bank_wen, bank_wdata, bank_addr); end
    tick(1);
    checks++; if (corrections !== 16'd1) begin failures++; $display("FAIL single_corr got=%0d exp=1", corrections); end
    checks++; if (last_fault_addr !== 2'd1) begin failures++; $display("FAIL single_lfa got=%0d exp=1", last_fault_addr); end
    checks++; if (triple_fault !== 1'b0 || scrub_busy !== 1'b0) begin failures++; $display("FAIL single_after got triple=%b busy=%b exp 0/0", triple_fault, scrub_busy); end
    checks++; if (mem[1][1] !== 32'h0) begin failures++; $display("FAIL single_repaired got=%h exp=0", mem[1][1]); end
    scrub_en = 1'b0;
  endtask

  task automatic test_triple_fault;
    load(0, 2, 32'h1);
    load(1, 2, 32'h2);
    load(2, 2, 32'h4);
    scrub_en = 1'b1;
    tick(4);
    checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'd2) begin failures++; $display("FAIL triple_read got=%b/%h exp=1/2", bank_ren, bank_addr); end
    tick(1);
    checks++; if (triple_fault !== 1'b0) begin failures++; $display("FAIL triple_early got=%b exp=0", triple_fault); end
    tick(1);
    checks++; if (triple_fault !== 1'b1 || last_fault_addr !== 2'd2) begin failures++; $display("FAIL triple_pulse got=%b lfa=%0d exp 1/2", triple_fault, last_fault_addr); end
    checks++; if (bank_wen !== 3'b111 || bank_wdata !== 32'h0) begin failures++; $display("FAIL triple_write got wen=%b wdata=%h exp 111/0", bank_wen, bank_wdata); end
    tick(1);
    checks++; if (triple_fault !== 1'b0 || corrections !== 16'd2) begin failures++; $display("FAIL triple_after got triple=%b corr=%0d exp 0/2", triple_fault, corrections); end
    scrub_en = 1'b0;
  endtask

  task automatic test_functional_priority;
    scrub_en = 1'b1;
    tick(3);
    voted_ren = 1'b1; voted_addr = 32'h123; #1;
    checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'h123) begin failures++; $display("FAIL prio_idle got=%b/%h exp=1/123", bank_ren, bank_addr); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'h123 || bank_wen !== 3'b000 || scrub_busy !== 1'b1) begin
        failures++; $display("FAIL prio_hold i=%0d got ren=%b addr=%h wen=%b busy=%b exp 1/123/000/1", i, bank_ren, bank_addr, bank_wen, scrub_busy); end
    end
    tick(1);
    voted_ren = 1'b0; voted_addr = '0; #1;
    checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'd3) begin failures++; $display("FAIL prio_scrub_read got=%b/%h exp=1/3", bank_ren, bank_addr); end
    tick(2);
    checks++; if (pass_done !== 1'b1 || scrub_busy !== 1'b0) begin failures++; $display("FAIL prio_wrap got pass=%b busy=%b exp 1/0", pass_done, scrub_busy); end
    scrub_en = 1'b0;
  endtask

  task automatic test_hazard;
    load(0, 0, 32'hF0);
    scrub_en = 1'b1;
    tick(6);
    voted_wen = 1'b1; voted_addr = 32'd0; voted_wdata = 32'hABCD; #1;
    checks++; if (bank_wen !== 3'b111 || bank_wdata !== 32'hABCD || bank_addr !== 32'd0) begin
      failures++; $display("FAIL hazard_write got wen=%b wdata=%h addr=%h exp 111/abcd/0", bank_wen, bank_wdata, bank_addr); end
    tick(1);
    voted_wen = 1'b0; voted_wdata = '0;
    checks++; if (scrub_busy !== 1'b0 || corrections !== 16'd2 || last_fault_addr !== 2'd2) begin
      failures++; $display("FAIL hazard_abort got busy=%b corr=%0d lfa=%0d exp 0/2/2", scrub_busy, corrections, last_fault_addr); end
    checks++; if (mem[0][0] !== 32'hABCD || mem[1][0] !== 32'hABCD) begin failures++; $display("FAIL hazard_mem got=%h/%h exp=abcd", mem[0][0], mem[1][0]); end
    tick(4);
    checks++; if (bank_ren !== 1'b1 || bank_addr !== 32'd0) begin failures++; $display("FAIL hazard_rescan got=%b/%h exp=1/0", bank_ren, bank_addr); end
    tick(2);
    checks++; if (corrections !== 16'd2 || scrub_busy !== 1'b0) begin failures++; $display("FAIL hazard_clean got corr=%0d busy=%b exp 2/0", corrections, scrub_busy); end
    scrub_en = 1'b0;
  endtask

  task automatic test_saturation;
    // Jump the counter to its ceiling rather than replaying 65k faults.
    tick(1);
    force dut.corr_q = 16'hFFFF;
    tick(1);
    release dut.corr_q;
    checks++; if (corrections !== 16'hFFFF) begin failures++; $display("FAIL sat_preload got=%h exp=ffff", corrections); end
    load(1, 1, 32'h5);
    scrub_en = 1'b1;
    tick(4);
    checks++; if (bank_addr !== 32'd1) begin failures++; $display("FAIL sat_read got=%h exp=1", bank_addr); end
    tick(2);
    checks++; if (bank_wen !== 3'b010) begin failures++; $display("FAIL sat_write got=%b exp=010", bank_wen); end
    tick(1);
    checks++; if (corrections !== 16'hFFFF || last_fault_addr !== 2'd1) begin failures++; $display("FAIL sat_hold got corr=%h lfa=%0d exp ffff/1", corrections, last_fault_addr); end
    scrub_en = 1'b0;
  endtask

  task automatic test_reset_in_write;
    load(2, 2, 32'h7);
    scrub_en = 1'b1;
    tick(6);
    checks++; if (bank_wen !== 3'b100 || bank_addr !== 32'd2) begin failures++; $display("FAIL rstw_write got wen=%b addr=%h exp 100/2", bank_wen, bank_addr); end
    rst_n = 1'b0; #1;
    checks++; if ({bank_wen, bank_ren} !== 4'b0000 || scrub_busy !== 1'b0) begin failures++; $display("FAIL rstw_en got=%b busy=%b exp 0000/0", {bank_wen, bank_ren}, scrub_busy); end
    checks++; if (corrections !== 16'h0 || last_fault_addr !== 2'd0) begin failures++; $display("FAIL rstw_regs got corr=%h lfa=%0d exp 0/0", corrections, last_fault_addr); end
    checks++; if ({triple_fault, pass_done} !== 2'b00) begin failures++; $display("FAIL rstw_pulses got=%b exp=00", {triple_fault, pass_done}); end
    voted_wen = 1'b1; voted_addr = 32'h77; #1;
    checks++; if (bank_wen !== 3'b111 || bank_addr !== 32'h77) begin failures++; $display("FAIL rstw_passthru got=%b/%h exp=111/77", bank_wen, bank_addr); end
    voted_wen = 1'b0; voted_addr = '0;
    tick(1);
    checks++; if (mem[2][2] !== 32'h7) begin failures++; $display("FAIL rstw_nowrite got=%h exp=7", mem[2][2]); end
    scrub_en = 1'b0;
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_clean_pass;
    test_single_correction;
    test_triple_fault;
    test_functional_priority;
    test_hazard;
    test_saturation;
    test_reset_in_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
